// File: rtl/hazard_ctrl.sv
// Purpose : load-use / branch / memory-wait hazard controller for a 5-stage pipeline.
// Latency : all control outputs are combinational from state and inputs (zero cycles).
// Backpr. : memBusy freezes the back end (pipeHold) and the front end (pcHold/ifIdHold).
//
// Ports:
//   clk, reset (async, active-low)
//   idRs1/idRs2/idUsesRs1/idUsesRs2 : ID-stage source operands
//   exRd/exLw/exTaken               : EX-stage destination, load flag, PC redirect
//   memBusy                         : data memory not completing this cycle
//   pcHold/ifIdHold/ifIdFlush/idExBubble/pipeHold : pipeline control
//   memTimeout                      : sticky memory-wait timeout flag
//   state                           : RUN=0, LU_STALL=1, MEM_WAIT=2
//   stallCycles/flushCount          : performance counters (macro HAZARD_PERF_EN), else 0
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter logic [7:0]  MEM_TIMEOUT       = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    input  logic        idUsesRs1,
    input  logic        idUsesRs2,
    input  logic [4:0]  exRd,
    input  logic        exLw,
    input  logic        exTaken,
    input  logic        memBusy,
    output logic        pcHold,
    output logic        ifIdHold,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        pipeHold,
    output logic        memTimeout,
    output logic [1:0]  state,
    output logic [15:0] stallCycles,
    output logic [15:0] flushCount
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // The RUN cycle that detects the hazard is the first bubble, so the
    // stall state only covers the remaining LOAD_STALL_CYCLES-1 cycles.
    localparam logic [1:0] LU_LOAD  = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         LU_MULTI = (LOAD_STALL_CYCLES > 1);

    logic [1:0] state_q, state_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic       load_use;
    logic [7:0] wait_inc;
    logic       pc_hold_raw, ifid_hold_raw, ifid_flush_raw, bubble_raw, pipe_hold_raw;

    assign load_use = exLw && (exRd != 5'd0) &&
                      ((idUsesRs1 && (exRd == idRs1)) || (idUsesRs2 && (exRd == idRs2)));

    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q;
        wait_inc       = wait_cnt_q + 8'd1;
        pc_hold_raw    = 1'b0;
        ifid_hold_raw  = 1'b0;
        ifid_flush_raw = 1'b0;
        bubble_raw     = 1'b0;
        pipe_hold_raw  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (memBusy) begin
                    pc_hold_raw   = 1'b1;
                    ifid_hold_raw = 1'b1;
                    pipe_hold_raw = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = 8'd0;
                end else if (exTaken) begin
                    // The redirect squashes the ID instruction, so any
                    // load-use against it is moot.
                    ifid_flush_raw = 1'b1;
                    bubble_raw     = 1'b1;
                end else if (load_use) begin
                    pc_hold_raw   = 1'b1;
                    ifid_hold_raw = 1'b1;
                    bubble_raw    = 1'b1;
                    if (LU_MULTI) begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_LOAD;
                    end
                end
            end
            ST_LU_STALL: begin
                pc_hold_raw   = 1'b1;
                ifid_hold_raw = 1'b1;
                bubble_raw    = 1'b1;
                if (memBusy) begin
                    // Back end frozen: the bubble is not consumed, keep counting later.
                    pipe_hold_raw = 1'b1;
                end else if (lu_cnt_q <= 2'd1) begin
                    state_d  = ST_RUN;
                    lu_cnt_d = 2'd0;
                end else begin
                    lu_cnt_d = lu_cnt_q - 2'd1;
                end
            end
            ST_MEM_WAIT: begin
                pc_hold_raw   = 1'b1;
                ifid_hold_raw = 1'b1;
                pipe_hold_raw = 1'b1;
                wait_cnt_d    = wait_inc;
                if (wait_inc == MEM_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RUN;
                end else if (!memBusy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            lu_cnt_q   <= 2'd0;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Inputs may be live while reset is low; gate so nothing leaks out.
    assign pcHold     = reset & pc_hold_raw;
    assign ifIdHold   = reset & ifid_hold_raw;
    assign ifIdFlush  = reset & ifid_flush_raw;
    assign idExBubble = reset & bubble_raw;
    assign pipeHold   = reset & pipe_hold_raw;
    assign memTimeout = timeout_q;
    assign state      = state_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (pcHold && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ifIdFlush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`else
    assign stallCycles = 16'd0;
    assign flushCount  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl, two instances (L=2/TO=20, L=3/TO=3).
// Latency : outputs checked combinationally 1 time unit after inputs change.
// Backpr. : memBusy bursts drive both MEM_WAIT and timeout paths.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        idUsesRs1, idUsesRs2, exLw, exTaken, memBusy;

    logic [1:0]  pc_w, ifh_w, fl_w, bub_w, ph_w, tmo_w;
    logic [1:0]  st_w [2];
    logic [15:0] sc_w [2];
    logic [15:0] fc_w [2];

    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(8'd20)) u_a (
        .clk(clk), .reset(reset), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .exRd(exRd), .exLw(exLw),
        .exTaken(exTaken), .memBusy(memBusy),
        .pcHold(pc_w[0]), .ifIdHold(ifh_w[0]), .ifIdFlush(fl_w[0]),
        .idExBubble(bub_w[0]), .pipeHold(ph_w[0]), .memTimeout(tmo_w[0]),
        .state(st_w[0]), .stallCycles(sc_w[0]), .flushCount(fc_w[0])
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8'd3)) u_b (
        .clk(clk), .reset(reset), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .exRd(exRd), .exLw(exLw),
        .exTaken(exTaken), .memBusy(memBusy),
        .pcHold(pc_w[1]), .ifIdHold(ifh_w[1]), .ifIdFlush(fl_w[1]),
        .idExBubble(bub_w[1]), .pipeHold(ph_w[1]), .memTimeout(tmo_w[1]),
        .state(st_w[1]), .stallCycles(sc_w[1]), .flushCount(fc_w[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: remaining bubbles, waiting flag and cycles waited.
    int m_bub    [2];
    bit m_wait   [2];
    int m_waited [2];
    bit m_tmo    [2];
    int m_sc     [2];
    int m_fc     [2];

    function automatic int lsc(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int mto(input int k);
        return (k == 0) ? 20 : 3;
    endfunction

    function automatic bit load_use();
        return exLw && (exRd != 0) &&
               ((idUsesRs1 && exRd == idRs1) || (idUsesRs2 && exRd == idRs2));
    endfunction

    task automatic model_outs(input int k, output bit pc, output bit ifh, output bit fl,
                              output bit bub, output bit ph);
        pc = 0; ifh = 0; fl = 0; bub = 0; ph = 0;
        if (reset) begin
            if (m_wait[k]) begin
                pc = 1; ifh = 1; ph = 1;
            end else if (m_bub[k] > 0) begin
                pc = 1; ifh = 1; bub = 1; ph = memBusy;
            end else if (memBusy) begin
                pc = 1; ifh = 1; ph = 1;
            end else if (exTaken) begin
                fl = 1; bub = 1;
            end else if (load_use()) begin
                pc = 1; ifh = 1; bub = 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_bub[k] = 0; m_wait[k] = 0; m_waited[k] = 0;
            m_tmo[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit pc, ifh, fl, bub, ph;
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                model_outs(k, pc, ifh, fl, bub, ph);
                if (pc && m_sc[k] < 65535) m_sc[k]++;
                if (fl && m_fc[k] < 65535) m_fc[k]++;
                if (m_wait[k]) begin
                    m_waited[k]++;
                    if (m_waited[k] == mto(k)) begin
                        m_tmo[k]  = 1;
                        m_wait[k] = 0;
                    end else if (!memBusy) begin
                        m_wait[k] = 0;
                    end
                end else if (m_bub[k] > 0) begin
                    if (!memBusy) m_bub[k]--;
                end else if (memBusy) begin
                    m_wait[k]   = 1;
                    m_waited[k] = 0;
                end else if (!exTaken && load_use()) begin
                    m_bub[k] = lsc(k) - 1;
                end
            end
        end
    endtask

    task automatic check_now();
        bit pc, ifh, fl, bub, ph;
        int est;
        string nm;
        for (int k = 0; k < 2; k++) begin
            nm = (k == 0) ? "a" : "b";
            model_outs(k, pc, ifh, fl, bub, ph);
            est = m_wait[k] ? 2 : ((m_bub[k] > 0) ? 1 : 0);
            chk($sformatf("%s.pcHold", nm),     32'(pc_w[k]),  32'(pc));
            chk($sformatf("%s.ifIdHold", nm),   32'(ifh_w[k]), 32'(ifh));
            chk($sformatf("%s.ifIdFlush", nm),  32'(fl_w[k]),  32'(fl));
            chk($sformatf("%s.idExBubble", nm), 32'(bub_w[k]), 32'(bub));
            chk($sformatf("%s.pipeHold", nm),   32'(ph_w[k]),  32'(ph));
            chk($sformatf("%s.memTimeout", nm), 32'(tmo_w[k]), 32'(m_tmo[k]));
            chk($sformatf("%s.state", nm),      32'(st_w[k]),  32'(est));
            chk($sformatf("%s.stallCycles", nm), 32'(sc_w[k]), PERF ? 32'(m_sc[k]) : 32'd0);
            chk($sformatf("%s.flushCount", nm),  32'(fc_w[k]), PERF ? 32'(m_fc[k]) : 32'd0);
        end
    endtask

    // Entered at a falling edge with inputs applied; leaves at the next falling edge.
    task automatic step();
        #1;
        check_now();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        idRs1 = 0; idRs2 = 0; exRd = 0;
        idUsesRs1 = 0; idUsesRs2 = 0; exLw = 0; exTaken = 0; memBusy = 0;
    endtask

    int cnt_a, cnt_b, burst;
    logic [15:0] fc0;

    initial begin
        // Reset with every input active: nothing may come out.
        reset = 0;
        set_idle();
        memBusy = 1; exTaken = 1; exLw = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        model_reset();
        @(negedge clk);
        step();
        step();
        reset = 1;
        set_idle();
        step();

        // Load-use on rs1: 2 bubble cycles on a, 3 on b.
        cnt_a = 0; cnt_b = 0;
        exLw = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) set_idle();
            #1;
            cnt_a += int'(pc_w[0] & ifh_w[0] & bub_w[0]);
            cnt_b += int'(pc_w[1] & ifh_w[1] & bub_w[1]);
            step();
        end
        chk("lu_a_cycles", 32'(cnt_a), 32'd2);
        chk("lu_b_cycles", 32'(cnt_b), 32'd3);
        chk("lu_a_end_state", 32'(st_w[0]), 32'd0);

        // x0 destination and unused rs2 never stall.
        exLw = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
        #1 chk("x0_nostall", 32'(pc_w), 32'd0);
        step();
        exRd = 5; idRs1 = 1; idUsesRs1 = 0; idRs2 = 5; idUsesRs2 = 0;
        #1 chk("unused_rs2_nostall", 32'(pc_w), 32'd0);
        step();
        set_idle();
        step();

        // Branch redirect wins over load-use.
        fc0 = fc_w[0];
        exTaken = 1; exLw = 1; exRd = 7; idRs2 = 7; idUsesRs2 = 1;
        #1;
        chk("br_flush", 32'(fl_w), 32'd3);
        chk("br_bubble", 32'(bub_w), 32'd3);
        chk("br_pchold", 32'(pc_w), 32'd0);
        step();
        set_idle();
        #1;
        chk("br_state_a", 32'(st_w[0]), 32'd0);
        chk("br_state_b", 32'(st_w[1]), 32'd0);
        chk("br_flushcount", 32'(fc_w[0] - fc0), PERF ? 32'd1 : 32'd0);
        step();

        // memBusy 4 cycles: pipeHold 5 cycles on a, no timeout.
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            memBusy = (i < 4);
            #1;
            cnt_a += int'(ph_w[0]);
            step();
        end
        chk("mw_pipehold_cycles", 32'(cnt_a), 32'd5);
        chk("mw_end_state", 32'(st_w[0]), 32'd0);
        chk("mw_no_timeout", 32'(tmo_w[0]), 32'd0);
        reset = 0;
        model_reset();
        step();
        reset = 1;
        step();

        // Timeout on b (MEM_TIMEOUT=3) with memBusy held.
        memBusy = 1;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("to_flag", 32'(tmo_w[1]), 32'd1);
        chk("to_state", 32'(st_w[1]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            memBusy = (i < 3);
            step();
        end
        chk("to_sticky", 32'(tmo_w[1]), 32'd1);
        reset = 0;
        model_reset();
        #1 chk("to_cleared", 32'(tmo_w[1]), 32'd0);
        @(negedge clk);
        step();
        reset = 1;
        set_idle();
        step();

        // Reset mid-LU_STALL acts without a clock edge.
        exLw = 1; exRd = 3; idRs1 = 3; idUsesRs1 = 1;
        step();
        set_idle();
        step();
        #1 chk("pre_rst_b_in_lu", 32'(st_w[1]), 32'd1);
        #2;
        reset = 0;
        model_reset();
        #1;
        chk("midrst_pchold", 32'(pc_w), 32'd0);
        chk("midrst_bubble", 32'(bub_w), 32'd0);
        chk("midrst_state_b", 32'(st_w[1]), 32'd0);
        check_now();
        @(negedge clk);
        step();
        reset = 1;
        step();
        #1 chk("post_rst_no_hold", 32'(pc_w | ifh_w | ph_w), 32'd0);

        // Randomized traffic against the model.
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            if (!reset) model_reset();
            exLw      = 1'($urandom_range(0, 1));
            exRd      = 5'($urandom_range(0, 3));
            idRs1     = 5'($urandom_range(0, 3));
            idRs2     = 5'($urandom_range(0, 3));
            idUsesRs1 = 1'($urandom_range(0, 1));
            idUsesRs2 = 1'($urandom_range(0, 1));
            exTaken   = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(3, 25);
            if (burst > 0) begin
                memBusy = 1;
                burst--;
            end else begin
                memBusy = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, range 1..3, giving the number of bubble cycles inserted per load-use hazard.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 8'd200, range 1..255, giving the maximum number of MEM_WAIT cycles before a timeout.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports idRs1, idRs2, input, 5 bits each: source register addresses of the instruction in ID.
REQ-006 SHALL have ports idUsesRs1, idUsesRs2, input, 1 bit each: the ID instruction reads that source register.
REQ-007 SHALL have port exRd, input, 5 bits, and port exLw, input, 1 bit: destination register and load flag of the instruction in EX.
REQ-008 SHALL have port exTaken, input, 1 bit: a branch, jump or jalr in EX redirects the PC this cycle.
REQ-009 SHALL have port memBusy, input, 1 bit: data memory cannot complete this cycle.
REQ-010 SHALL have outputs pcHold, ifIdHold, ifIdFlush, idExBubble and pipeHold, 1 bit each.
- idExBubble drives the ID/EX stall input.
- pipeHold freezes ID/EX, EX/MEM and MEM/WB.
REQ-011 SHALL have output memTimeout, 1 bit: sticky timeout error flag.
REQ-012 SHALL have output state, 2 bits, encoded RUN=0, LU_STALL=1, MEM_WAIT=2.
REQ-013 SHALL have outputs stallCycles and flushCount, 16 bits each (see Configuration).

Function
REQ-014 SHALL compute loadUse combinationally as: exLw & (exRd!=0) & ((idUsesRs1 & exRd==idRs1) | (idUsesRs2 & exRd==idRs2)).
REQ-015 SHALL drive all control outputs combinationally from the current state and inputs, with no added latency.
REQ-016 SHALL, in RUN, apply the following priority:
- memBusy: assert pcHold, ifIdHold and pipeHold; next state MEM_WAIT.
- else exTaken: assert ifIdFlush and idExBubble; next state RUN.
- else loadUse: assert pcHold, ifIdHold and idExBubble; next state is LU_STALL when LOAD_STALL_CYCLES>1, otherwise RUN.
- else: no outputs asserted.
REQ-017 SHALL, on entry to LU_STALL, load a 2-bit counter with LOAD_STALL_CYCLES-1.
REQ-018 SHALL, in LU_STALL, assert pcHold, ifIdHold and idExBubble, decrement the counter each cycle, and return to RUN after the cycle in which the counter equals 1.
REQ-019 SHALL, in LU_STALL with memBusy=1, additionally assert pipeHold, freeze the counter and remain in LU_STALL.
REQ-020 SHALL ignore exTaken and loadUse while in LU_STALL.
REQ-021 SHALL, in MEM_WAIT, assert pcHold, ifIdHold and pipeHold, and increment an 8-bit wait counter each cycle.
REQ-022 SHALL clear the wait counter on every MEM_WAIT entry.
REQ-023 SHALL return from MEM_WAIT to RUN on the first cycle memBusy=0; RUN rules apply in the cycle after exit.
REQ-024 SHALL, when the wait counter reaches MEM_TIMEOUT, set memTimeout, hold it until reset, and force the next state to RUN.
REQ-025 SHALL never assert ifIdFlush and ifIdHold in the same cycle.
REQ-026 SHALL never assert idExBubble together with pipeHold, except in LU_STALL with memBusy=1.

Reset
REQ-027 SHALL, while reset=0, force:
- state to RUN;
- both counters to 0;
- memTimeout to 0;
- stallCycles and flushCount to 0.
REQ-028 SHALL hold every control output at 0 while in reset.
REQ-029 SHALL discard any in-progress stall or wait on a reset assertion mid-operation, and start in RUN after reset release with no residual hold.

Configuration
REQ-030 SHALL, when macro HAZARD_PERF_EN is defined, keep the following saturating counters, each stopping at 16'hFFFF:
- stallCycles: increments every cycle pcHold=1.
- flushCount: increments every cycle ifIdFlush=1.
REQ-031 SHALL, when HAZARD_PERF_EN is undefined, omit both counter registers and tie stallCycles and flushCount to 0.

Verification
REQ-032 SHALL cover load-use: exLw=1, exRd=5, idRs1=5, idUsesRs1=1, LOAD_STALL_CYCLES=2 -> pcHold, ifIdHold and idExBubble high for exactly 2 cycles, then RUN.
REQ-033 SHALL cover x0 and unused sources:
- exRd=0 with matching idRs1 -> no stall.
- exRd=5, idRs2=5, idUsesRs2=0 -> no stall.
REQ-034 SHALL cover simultaneous exTaken=1 and loadUse -> ifIdFlush=1, idExBubble=1, pcHold=0, state stays RUN; flushCount +1.
REQ-035 SHALL cover memBusy high 4 cycles from RUN -> pipeHold high 5 cycles (entry plus MEM_WAIT), then RUN with memTimeout=0.
REQ-036 SHALL cover MEM_TIMEOUT=3 with memBusy held high -> memTimeout=1 after the third MEM_WAIT cycle, state RUN, flag kept until reset=0.
REQ-037 SHALL cover reset=0 asserted mid-LU_STALL -> state=0 and all outputs 0 immediately, without waiting for a clock edge.
